vector_add_arbiter: RTL and testbench
=====================================

Name: vector_add_arbiter

Overview:
Shares one vector-adder datapath (start/finish handshake, VECTOR_SIZE lanes of CELL_WIDTH inputs, CELL_WIDTH+1-bit sums) between NUM_REQ requesters, e.g. the weight-update and bias-update paths of the backprop engine. The arbiter uses round-robin arbitration and latches the winner's operands. It issues a one-cycle start to the adder, waits for finish, then returns the result with a one-cycle done pulse to the granted requester. It sits between the layer controllers and the single adder instance.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
VECTOR_SIZE, 5, lanes per vector
CELL_WIDTH, 8, bits per input lane
TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  level request per requester
req_a  in  NUM_REQ*VECTOR_SIZE*CELL_WIDTH  operand A per requester; requester r occupies slice r
req_b  in  NUM_REQ*VECTOR_SIZE*CELL_WIDTH  operand B per requester, same packing
done  out  NUM_REQ  one-hot, one-cycle completion pulse
grant  out  NUM_REQ  one-hot current owner; 0 when idle
result  out  VECTOR_SIZE*(CELL_WIDTH+1)  last captured sum vector
busy  out  1  high in every state except IDLE
add_start  out  1  one-cycle start to the adder
add_a  out  VECTOR_SIZE*CELL_WIDTH  latched operand A
add_b  out  VECTOR_SIZE*CELL_WIDTH  latched operand B
add_result  in  VECTOR_SIZE*(CELL_WIDTH+1)  adder output
add_finish  in  1  adder completion pulse
error  out  1  timeout pulse; tied 0 without the optional feature

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 has highest priority); latched operands 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, with any req bit high:
  - Select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register grant as one-hot and latch that requester's req_a/req_b into add_a/add_b.
  - Set pointer = winner+1 (mod NUM_REQ). Go to ISSUE.
- IDLE, with req all 0: stay in IDLE; grant=0.
- ISSUE: add_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold add_start=0 and hold the operands stable.
  - On add_finish=1, capture add_result into result and go to DONE.
  - An add_finish seen in IDLE, ISSUE or DONE is ignored.
- DONE:
  - done[winner]=1 for one cycle; grant is held this cycle; go to IDLE.
  - grant returns to 0 in the next IDLE cycle unless a new arbitration wins.
- Minimum transaction: 3 cycles plus adder latency (grant cycle, ISSUE, WAIT..finish, DONE).
  - Done appears 1 cycle after the finish cycle.
  - Back-to-back grants are separated by exactly one IDLE cycle.
- Requests are level-sensitive and are sampled only in IDLE.
  - A requester deasserts req on the cycle after its done pulse.
  - A req still high in the following IDLE is treated as a new request.
  - req changes during ISSUE, WAIT or DONE have no effect.
- Operand changes on req_a/req_b after the grant cycle do not affect the transaction.
- result holds its value until the next capture.
- rst in any state returns to IDLE at the next edge. No done is issued for an aborted transaction and add_start is deasserted.

Optional Feature:
VADD_ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without add_finish, the arbiter pulses error=1 for one cycle, writes result=0 and goes to DONE, so done still pulses to the owner.
  - If add_finish arrives in the same cycle the limit is reached, finish wins and error stays 0.
- Undefined: no counter; WAIT lasts indefinitely; error is constant 0.

Test Plan:
1. Reset, then req=3'b000 for 10 cycles -> grant=0, busy=0, add_start never asserted, done=0.
2. req=3'b010; A lanes all 200, B lanes all 100; adder finishes 5 cycles after start -> grant=3'b010 one cycle later, single add_start pulse, each result lane=300 (9-bit), done=3'b010 exactly one cycle after add_finish.
3. req=3'b111 held continuously -> grants in order 001, 010, 100, 001; exactly one IDLE cycle between each DONE and the next grant.
4. Requester 0 changes req_a to all 7 during WAIT (granted operand was all 1, B all 2) -> result lanes=3, not 9.
5. Assert rst during WAIT with requester 2 granted -> next cycle grant=0, busy=0, no done pulse; a fresh req=3'b100 then completes normally.
6. With VADD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, adder never finishes -> error pulses 8 WAIT cycles after ISSUE, result=0, done pulses to the owner. Repeat with finish on cycle 8 -> error=0 and the sum is captured.

Source files
------------

// File: rtl/vector_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// vector_add_arbiter_if
// Bundles the requester-side and adder-side signals of vector_add_arbiter.
//   slave  modport : the arbiter's view (takes requests and adder results,
//                    drives grants, done pulses, result and adder operands)
//   master modport : the environment's view (requesters plus adder instance)
// Signals:
//   req        requester level requests, one bit per requester
//   req_a/b    requester operands, requester r in slice r
//   done       one-hot completion pulse to the owner
//   grant      one-hot current owner, 0 when idle
//   result     last captured sum vector (CELL_WIDTH+1 bits per lane)
//   busy       arbiter not idle
//   add_start  one-cycle start to the adder
//   add_a/b    latched operands presented to the adder
//   add_result adder output, add_finish adder completion pulse
//   error      WAIT timeout pulse (only with VADD_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
interface vector_add_arbiter_if #(
  parameter int NUM_REQ     = 3,
  parameter int VECTOR_SIZE = 5,
  parameter int CELL_WIDTH  = 8
);
  localparam int OP_W  = VECTOR_SIZE * CELL_WIDTH;
  localparam int RES_W = VECTOR_SIZE * (CELL_WIDTH + 1);

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      done;
  logic [NUM_REQ-1:0]      grant;
  logic [RES_W-1:0]        result;
  logic                    busy;
  logic                    add_start;
  logic [OP_W-1:0]         add_a;
  logic [OP_W-1:0]         add_b;
  logic [RES_W-1:0]        add_result;
  logic                    add_finish;
  logic                    error;

  modport slave (
    input  req, req_a, req_b, add_result, add_finish,
    output done, grant, result, busy, add_start, add_a, add_b, error
  );

  modport master (
    output req, req_a, req_b, add_result, add_finish,
    input  done, grant, result, busy, add_start, add_a, add_b, error
  );
endinterface

// File: rtl/vector_add_arbiter.sv
// ---------------------------------------------------------------------------
// vector_add_arbiter
// Round-robin arbiter sharing one vector adder between NUM_REQ requesters.
// The winner's operands are latched, the adder gets a one-cycle start, and
// on finish the sum is captured and a one-cycle done goes to the owner.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  vector_add_arbiter_if.slave (requests, grants, done, result, busy,
//        adder start/operands/result/finish, error)
// Optional build macro:
//   VADD_ARB_TIMEOUT_EN  WAIT-state timeout after TIMEOUT_CYCLES cycles:
//                        error pulse, result forced to 0, done still issued.
//                        Without it error is constant 0 and WAIT is unbounded.
// ---------------------------------------------------------------------------
module vector_add_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int VECTOR_SIZE    = 5,
  parameter int CELL_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  vector_add_arbiter_if.slave bus
);
  localparam int OP_W  = VECTOR_SIZE * CELL_WIDTH;
  localparam int RES_W = VECTOR_SIZE * (CELL_WIDTH + 1);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [NUM_REQ-1:0] REQ_ZERO = {NUM_REQ{1'b0}};
  localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1'b1);
  localparam logic [PTR_W-1:0]   PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [OP_W-1:0]    OP_ZERO  = {OP_W{1'b0}};
  localparam logic [RES_W-1:0]   RES_ZERO = {RES_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [OP_W-1:0]    add_a_q, add_a_d;
  logic [OP_W-1:0]    add_b_q, add_b_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               add_start_q, add_start_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;

  logic               hi_vld_s, lo_vld_s, win_vld_s;
  logic [PTR_W-1:0]   hi_idx_s, lo_idx_s, win_idx_s;
  logic               timeout_s;

  // Round-robin pick: lowest request at or above the pointer, else lowest overall.
  always_comb begin
    hi_vld_s = 1'b0;
    lo_vld_s = 1'b0;
    hi_idx_s = PTR_ZERO;
    lo_idx_s = PTR_ZERO;
    // Scan downwards so the lowest qualifying index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_vld_s = 1'b1;
        lo_idx_s = i[PTR_W-1:0];
        if (i >= int'(ptr_q)) begin
          hi_vld_s = 1'b1;
          hi_idx_s = i[PTR_W-1:0];
        end else begin
          hi_vld_s = hi_vld_s;
        end
      end else begin
        lo_vld_s = lo_vld_s;
      end
    end
    win_vld_s = lo_vld_s;
    if (hi_vld_s) begin
      win_idx_s = hi_idx_s;
    end else begin
      win_idx_s = lo_idx_s;
    end
  end

`ifdef VADD_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // WAIT-cycle counter: zero outside WAIT, so it starts from zero on every WAIT entry.
  always_comb begin
    if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1'b1);
    end else begin
      tmo_cnt_d = {TMO_W{1'b0}};
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // The count holds completed WAIT cycles, so the limit is hit on the
  // TIMEOUT_CYCLES-th WAIT cycle; a finish in that same cycle takes priority.
  assign timeout_s = (state_q == ST_WAIT) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) &&
                     !bus.add_finish;
`else
  assign timeout_s = 1'b0;
`endif

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_ZERO;
      grant_q     <= REQ_ZERO;
      done_q      <= REQ_ZERO;
      add_a_q     <= OP_ZERO;
      add_b_q     <= OP_ZERO;
      result_q    <= RES_ZERO;
      add_start_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      result_q    <= result_d;
      add_start_q <= add_start_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic; add_finish only matters in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.add_finish || timeout_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; each pulse is armed on the
  // transition into the state where it must be visible.
  always_comb begin
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    result_d    = result_q;
    done_d      = REQ_ZERO;
    add_start_d = 1'b0;
    error_d     = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (win_vld_s) begin
          grant_d     = REQ_ONE << win_idx_s;
          ptr_d       = (win_idx_s == PTR_LAST) ? PTR_ZERO : (win_idx_s + PTR_ONE);
          add_a_d     = bus.req_a[win_idx_s*OP_W +: OP_W];
          add_b_d     = bus.req_b[win_idx_s*OP_W +: OP_W];
          add_start_d = 1'b1;
        end else begin
          grant_d = REQ_ZERO;
        end
      end
      ST_ISSUE: begin
        grant_d = grant_q;
      end
      ST_WAIT: begin
        if (bus.add_finish) begin
          result_d = bus.add_result;
          done_d   = grant_q;
        end else if (timeout_s) begin
          result_d = RES_ZERO;
          done_d   = grant_q;
          error_d  = 1'b1;
        end else begin
          result_d = result_q;
        end
      end
      ST_DONE: begin
        // Grant is held through DONE and released for the following IDLE.
        grant_d = REQ_ZERO;
      end
      default: begin
        grant_d = REQ_ZERO;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.result    = result_q;
  assign bus.add_start = add_start_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;
endmodule

// File: tb/tb_vector_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vector_add_arbiter
// Self-checking bench for vector_add_arbiter: table-driven transactions plus
// hand-written sequences; a behavioural adder answers add_start after a
// programmable latency, and a scoreboard of expected done/result entries is
// popped whenever the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_vector_add_arbiter;
  localparam int NR   = 3;
  localparam int VS   = 5;
  localparam int CW   = 8;
  localparam int TMO  = 8;
  localparam int OPW  = VS * CW;
  localparam int RESW = VS * (CW + 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vector_add_arbiter_if #(.NUM_REQ(NR), .VECTOR_SIZE(VS), .CELL_WIDTH(CW)) bus ();

  vector_add_arbiter #(
    .NUM_REQ(NR), .VECTOR_SIZE(VS), .CELL_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NR-1:0]   gnt;
    logic [RESW-1:0] res;
    logic            err;
  } exp_t;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [CW-1:0] a;
    logic [CW-1:0] a_inc;
    logic [CW-1:0] b;
    logic [CW-1:0] b_inc;
    int            lat;
  } vec_t;

  exp_t sb[$];
  vec_t vec[7];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ndone = 0;
  int nstart = 0;
  int nerr = 0;
  int txn_starts = 0;
  int last_fin_cyc = 0;
  int last_done_cyc = 0;
  int err_cyc = 0;
  int acnt = 0;
  int alat = 0;
  logic stray_fin = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OPW-1:0] pattern(input logic [CW-1:0] base, input logic [CW-1:0] inc);
    logic [OPW-1:0] v;
    for (int l = 0; l < VS; l++) v[l*CW +: CW] = base + CW'(l) * inc;
    return v;
  endfunction

  function automatic logic [RESW-1:0] lane_sum(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [RESW-1:0] s;
    for (int l = 0; l < VS; l++)
      s[l*(CW+1) +: CW+1] = {1'b0, a[l*CW +: CW]} + {1'b0, b[l*CW +: CW]};
    return s;
  endfunction

  // One clock: sample at the falling edge, score done pulses, then drive the adder model.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.add_start) begin
      nstart++;
      txn_starts++;
    end
    if (bus.error) begin
      nerr++;
      err_cyc = cyc;
    end
    if (bus.done != '0) begin
      ndone++;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        chk("done_unexpected", 64'(bus.done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_owner", 64'(bus.done), 64'(e.gnt));
        chk("grant_held", 64'(bus.grant), 64'(e.gnt));
        chk("result", 64'(bus.result), 64'(e.res));
        chk("error_at_done", 64'(bus.error), 64'(e.err));
        chk("start_count", 64'(txn_starts), 64'd1);
        if (!e.err) chk("done_latency", 64'(cyc - last_fin_cyc), 64'd1);
      end
      txn_starts = 0;
    end
    bus.add_finish = 1'b0;
    bus.add_result = {RESW{1'b1}};
    if (stray_fin) begin
      bus.add_finish = 1'b1;
      stray_fin = 1'b0;
    end else if (acnt > 0) begin
      acnt--;
      if (acnt == 0) begin
        bus.add_finish = 1'b1;
        bus.add_result = lane_sum(bus.add_a, bus.add_b);
        last_fin_cyc = cyc;
      end
    end else if (bus.add_start && alat > 0) begin
      acnt = alat;
    end
  endtask

  task automatic wait_grant(output logic [NR-1:0] g);
    int n = 0;
    while (bus.grant == '0 && n < 50) begin
      step();
      n++;
    end
    chk("grant_seen", 64'(bus.grant != '0), 64'd1);
    g = bus.grant;
  endtask

  task automatic wait_done();
    int start = ndone;
    int n = 0;
    while (ndone == start && n < 200) begin
      step();
      n++;
    end
    chk("done_seen", 64'(ndone - start), 64'd1);
  endtask

  task automatic set_ops(input int r, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    bus.req_a[r*OPW +: OPW] = a;
    bus.req_b[r*OPW +: OPW] = b;
  endtask

  logic [NR-1:0]   g;
  logic [RESW-1:0] expv;
  int              issue_cyc;
  int              k;
  logic [NR-1:0]   rr_order[4];

  initial begin
    vec[0] = '{3'b010, 3'b010, 8'd200, 8'd0, 8'd100, 8'd0, 5};
    vec[1] = '{3'b011, 3'b001, 8'd17,  8'd3, 8'd40,  8'd1, 2};
    vec[2] = '{3'b110, 3'b010, 8'd128, 8'd9, 8'd127, 8'd7, 3};
    vec[3] = '{3'b101, 3'b100, 8'd5,   8'd50, 8'd250, 8'd1, 4};
    vec[4] = '{3'b100, 3'b100, 8'd255, 8'd0, 8'd255, 8'd0, 6};
    vec[5] = '{3'b001, 3'b001, 8'd0,   8'd0, 8'd0,   8'd0, 1};
    vec[6] = '{3'b101, 3'b100, 8'd99,  8'd11, 8'd1,  8'd13, 2};
    rr_order[0] = 3'b001;
    rr_order[1] = 3'b010;
    rr_order[2] = 3'b100;
    rr_order[3] = 3'b001;

    rst = 1'b1;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.add_finish = 1'b0;
    bus.add_result = '0;
    step();
    step();
    rst = 1'b0;
    step();
    // Reset state.
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_start", 64'(bus.add_start), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_add_a", 64'(bus.add_a), 64'd0);
    chk("rst_add_b", 64'(bus.add_b), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);

    // No requests: idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_grant_busy_done", 64'({bus.grant, bus.busy, bus.done}), 64'd0);
    end
    chk("idle_no_start", 64'(nstart), 64'd0);

    // A finish while idle must be ignored.
    stray_fin = 1'b1;
    step();
    step();
    step();
    chk("stray_fin_result", 64'(bus.result), 64'd0);
    chk("stray_fin_busy", 64'(bus.busy), 64'd0);
    chk("stray_fin_done", 64'(ndone), 64'd0);

    // All three requesting continuously: rotation 0,1,2,0 with one IDLE gap.
    for (int r = 0; r < NR; r++)
      set_ops(r, pattern(8'(10 * (r + 1)), 8'd1), pattern(8'd3, 8'd2));
    for (int i = 0; i < 4; i++) begin
      k = (i == 3) ? 0 : i;
      sb.push_back('{rr_order[i], lane_sum(pattern(8'(10 * (k + 1)), 8'd1), pattern(8'd3, 8'd2)), 1'b0});
    end
    alat = 2;
    bus.req = 3'b111;
    k = 0;
    g = '0;
    for (int n = 0; n < 200 && ndone < 4; n++) begin
      step();
      if (bus.grant != '0 && g == '0) begin
        chk("rr_order", 64'(bus.grant), 64'(rr_order[k]));
        if (k > 0) chk("rr_gap", 64'(cyc - last_done_cyc), 64'd2);
        k++;
      end
      g = bus.grant;
    end
    bus.req = '0;
    chk("rr_grants", 64'(k), 64'd4);
    step();
    chk("rr_idle_grant", 64'(bus.grant), 64'd0);

    // Table-driven single transactions.
    for (int t = 0; t < 7; t++) begin
      for (int r = 0; r < NR; r++) begin
        if (vec[t].gnt[r])
          set_ops(r, pattern(vec[t].a, vec[t].a_inc), pattern(vec[t].b, vec[t].b_inc));
        else
          set_ops(r, pattern(~vec[t].a, vec[t].a_inc), pattern(~vec[t].b, 8'd5));
      end
      expv = lane_sum(pattern(vec[t].a, vec[t].a_inc), pattern(vec[t].b, vec[t].b_inc));
      sb.push_back('{vec[t].gnt, expv, 1'b0});
      alat = vec[t].lat;
      bus.req = vec[t].req;
      wait_grant(g);
      chk("tbl_grant", 64'(g), 64'(vec[t].gnt));
      chk("tbl_issue_start", 64'(bus.add_start), 64'd1);
      chk("tbl_busy", 64'(bus.busy), 64'd1);
      bus.req = '0;
      wait_done();
      step();
      chk("tbl_idle_grant", 64'(bus.grant), 64'd0);
      chk("tbl_idle_busy", 64'(bus.busy), 64'd0);
      chk("tbl_result_hold", 64'(bus.result), 64'(expv));
    end

    // Operand change during WAIT must not reach the adder.
    set_ops(0, pattern(8'd1, 8'd0), pattern(8'd2, 8'd0));
    sb.push_back('{3'b001, lane_sum(pattern(8'd1, 8'd0), pattern(8'd2, 8'd0)), 1'b0});
    alat = 6;
    bus.req = 3'b001;
    wait_grant(g);
    chk("opchg_grant", 64'(g), 64'd1);
    bus.req = '0;
    step();
    set_ops(0, pattern(8'd7, 8'd0), pattern(8'd2, 8'd0));
    step();
    step();
    chk("opchg_add_a_stable", 64'(bus.add_a), 64'(pattern(8'd1, 8'd0)));
    wait_done();
    step();

    // Reset while waiting on requester 2: abort without done.
    alat = 0;
    bus.req = 3'b100;
    wait_grant(g);
    chk("abort_grant", 64'(g), 64'd4);
    bus.req = '0;
    step();
    step();
    step();
    k = ndone;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_grant_clear", 64'(bus.grant), 64'd0);
    chk("abort_busy_clear", 64'(bus.busy), 64'd0);
    chk("abort_start_low", 64'(bus.add_start), 64'd0);
    step();
    step();
    step();
    chk("abort_no_done", 64'(ndone - k), 64'd0);
    txn_starts = 0;
    set_ops(2, pattern(8'd60, 8'd4), pattern(8'd70, 8'd8));
    sb.push_back('{3'b100, lane_sum(pattern(8'd60, 8'd4), pattern(8'd70, 8'd8)), 1'b0});
    alat = 3;
    bus.req = 3'b100;
    wait_grant(g);
    chk("post_abort_grant", 64'(g), 64'd4);
    bus.req = '0;
    wait_done();
    step();

`ifdef VADD_ARB_TIMEOUT_EN
    // Adder never finishes: timeout on the 8th WAIT cycle, result forced to 0.
    set_ops(1, pattern(8'd33, 8'd1), pattern(8'd44, 8'd1));
    sb.push_back('{3'b010, {RESW{1'b0}}, 1'b1});
    alat = 0;
    bus.req = 3'b010;
    wait_grant(g);
    issue_cyc = cyc;
    bus.req = '0;
    wait_done();
    chk("tmo_error_cycle", 64'(err_cyc - issue_cyc), 64'd9);
    step();
    chk("tmo_error_pulses", 64'(nerr), 64'd1);
    // Finish on the limit cycle wins over the timeout.
    sb.push_back('{3'b010, lane_sum(pattern(8'd33, 8'd1), pattern(8'd44, 8'd1)), 1'b0});
    alat = TMO;
    bus.req = 3'b010;
    wait_grant(g);
    bus.req = '0;
    wait_done();
    step();
    chk("tmo_tie_no_error", 64'(nerr), 64'd1);
`else
    chk("no_error_pulses", 64'(nerr), 64'd0);
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
